// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES core among NUM_REQ requesters.
// One job in flight: grant, start pulse, wait for done (with watchdog), respond.
module aes_core_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      core_start,
  output logic [DATA_W-1:0]         core_data_in,
  input  logic                      core_done,
  input  logic [DATA_W-1:0]         core_data_out,
  output logic                      busy,
  output logic                      timeout_err
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, grant_id, winner, next_ptr;
  logic              found;
  logic [WD_W-1:0]   watchdog, wd_cnt;
  logic [DATA_W-1:0] job_q, result_q, job_sel;
  logic              timeout_err_q;
  logic              req_hs, resp_hs, wd_expire;

  // Two passes give a rotating priority: indices at/after rr_ptr first, then wrap.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
  end

  always_comb begin
    job_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) job_sel = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign wd_cnt    = watchdog + 1'b1;
  assign wd_expire = (state == WAIT) && !core_done && (wd_cnt == WD_W'(TIMEOUT));
  assign req_hs    = (state == IDLE) && found;
  assign resp_hs   = |(resp_valid & resp_ready);
  assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // NOTE: non-blocking assignments for every flop so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case, so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    core_start = 1'b0;
    unique case (state)
      IDLE: begin
        for (int i = 0; i < NUM_REQ; i++) req_ready[i] = found && (winner == ID_W'(i));
        if (found) state_nxt = START;
      end
      START: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        // Done on the final watchdog cycle still wins over the abort.
        if (core_done)      state_nxt = RESP;
        else if (wd_expire) state_nxt = IDLE;
      end
      RESP: begin
        for (int i = 0; i < NUM_REQ; i++) resp_valid[i] = (grant_id == ID_W'(i));
        if (resp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: job and result registers are reset because they drive core_data_in/resp_data directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr        <= '0;
      grant_id      <= '0;
      watchdog      <= '0;
      job_q         <= '0;
      result_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= wd_expire;
      if (req_hs) begin
        job_q    <= job_sel;
        grant_id <= winner;
      end
      if (state == START)     watchdog <= '0;
      else if (state == WAIT) watchdog <= wd_cnt;
      if ((state == WAIT) && core_done) result_q <= core_data_out;
      // Pointer moves only when a job finishes or is aborted, never on grant.
      if (resp_hs || wd_expire) rr_ptr <= next_ptr;
    end
  end

  assign core_data_in = job_q;
  assign resp_data    = result_q;
  assign busy         = (state != IDLE);
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Scoreboard bench for aes_core_arbiter: stimulus pushes expected grants/jobs/responses,
// monitors and a behavioural core model pop and compare.
module tb_aes_core_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 128;
  localparam int TIMEOUT = 64;

  localparam logic [DATA_W-1:0] D0 = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [DATA_W-1:0] D1 = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
  localparam logic [DATA_W-1:0] D2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DATA_W-1:0] D3 = 128'hf0f0f0f0a5a5a5a55a5a5a5a0f0f0f0f;
  localparam logic [DATA_W-1:0] R0 = 128'hfedcba9876543210fedcba9876543210;
  localparam logic [DATA_W-1:0] R1 = 128'h21524110215241102152411021524110;
  localparam logic [DATA_W-1:0] R2 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [DATA_W-1:0] R3 = 128'h0f0f0f0f5a5a5a5aa5a5a5a5f0f0f0f0;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid, req_ready, resp_valid, resp_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [DATA_W-1:0]         resp_data, core_data_in, core_data_out;
  logic                      core_start, core_done, busy, timeout_err;

  aes_core_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .core_start(core_start), .core_data_in(core_data_in),
    .core_done(core_done), .core_data_out(core_data_out),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [DATA_W-1:0] data; } resp_t;
  int                exp_grant_q[$];
  logic [DATA_W-1:0] exp_core_q[$];
  resp_t             exp_resp_q[$];

  int n_vec  = 0;
  int n_fail = 0;
  int core_lat = 30;   // 0 = core never completes
  bit spurious = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] onehot_of(input int id);
    logic [DATA_W-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  task automatic push_job(input int id, input logic [DATA_W-1:0] d, input bit with_resp,
                          input logic [DATA_W-1:0] r);
    resp_t e;
    exp_grant_q.push_back(id);
    exp_core_q.push_back(d);
    if (with_resp) begin
      e.id = id;
      e.data = r;
      exp_resp_q.push_back(e);
    end
  endtask

  task automatic drive_req(input logic [NUM_REQ-1:0] v);
    @(posedge clk); #1;
    req_valid = v;
  endtask

  task automatic wait_grant(output int t);
    bit got;
    got = 1'b0;
    t = -1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 0) begin
        got = 1'b1;
        t = cyc;
      end
    end
    check("grant_wait", got, 1);
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (exp_resp_q.size() == 0 && !busy) got = 1'b1;
    end
    check("done_wait", got, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"},    req_ready,    0);
    check({tag, "_resp_valid"},   resp_valid,   0);
    check({tag, "_core_start"},   core_start,   0);
    check({tag, "_busy"},         busy,         0);
    check({tag, "_timeout_err"},  timeout_err,  0);
    check({tag, "_resp_data"},    resp_data,    0);
    check({tag, "_core_data_in"}, core_data_in, 0);
  endtask

  // Grant monitor
  initial begin : grant_mon
    int e;
    forever begin
      @(negedge clk);
      if (req_ready != 0) check("req_ready_onehot", $onehot(req_ready), 1);
      if ((req_valid & req_ready) != 0) begin
        if (exp_grant_q.size() == 0) check("unexpected_grant", req_ready, 0);
        else begin
          e = exp_grant_q.pop_front();
          check("grant_id", req_ready, onehot_of(e));
        end
      end
    end
  end

  // Response monitor
  initial begin : resp_mon
    resp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid != 0) check("resp_valid_onehot", $onehot(resp_valid), 1);
      if ((resp_valid & resp_ready) != 0) begin
        if (exp_resp_q.size() == 0) check("unexpected_resp", resp_valid, 0);
        else begin
          e = exp_resp_q.pop_front();
          check("resp_id", resp_valid, onehot_of(e.id));
          check("resp_data", resp_data, e.data);
        end
      end
    end
  end

  // Core model: done L cycles after the start cycle, result = block XOR all-ones
  initial begin : core_model
    int cnt;
    logic prev_start;
    logic [DATA_W-1:0] blk;
    cnt = 0;
    prev_start = 1'b0;
    blk = '0;
    core_done = 1'b0;
    core_data_out = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        check("core_start_pulse", prev_start, 0);
        if (exp_core_q.size() == 0) check("unexpected_start", core_start, 0);
        else check("core_data_in", core_data_in, exp_core_q.pop_front());
        blk = core_data_in;
        cnt = core_lat;
      end
      prev_start = core_start;
      @(posedge clk); #1;
      core_done = 1'b0;
      if (!reset_n) cnt = 0;
      if (spurious) begin
        core_done = 1'b1;
        core_data_out = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
        spurious = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_done = 1'b1;
          core_data_out = blk ^ {DATA_W{1'b1}};
        end
      end
    end
  end

  initial begin : stim
    int t;
    int te_cnt;
    bit got;
    reset_n    = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    req_data   = {D3, D2, D1, D0};
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    reset_n    = 1'b1;
    resp_ready = 4'b1111;

    // Fairness: all requesters valid for 8 jobs
    for (int j = 0; j < 8; j++) begin
      case (j % 4)
        0: push_job(0, D0, 1, R0);
        1: push_job(1, D1, 1, R1);
        2: push_job(2, D2, 1, R2);
        default: push_job(3, D3, 1, R3);
      endcase
    end
    drive_req(4'b1111);
    for (int j = 0; j < 8; j++) wait_grant(t);
    drive_req(4'b0000);
    wait_done();

    // Single job, requester 2, latency 30
    push_job(2, D2, 1, R2);
    drive_req(4'b0100);
    wait_grant(t);
    check("single_busy_T", busy, 0);
    drive_req(4'b0000);
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      check("single_busy", busy, (n <= 32) ? 1 : 0);
      if (n == 1)  check("single_start_T1", core_start, 1);
      if (n == 2)  check("single_start_T2", core_start, 0);
      if (n == 31) check("single_resp_T31", resp_valid, 4'b0000);
      if (n == 32) check("single_resp_T32", resp_valid, 4'b0100);
    end
    wait_done();

    // Backpressure on requester 1, then 0 and 2 contend (rr_ptr lands on 2)
    resp_ready = 4'b1101;
    push_job(1, D1, 1, R1);
    drive_req(4'b0010);
    wait_grant(t);
    push_job(2, D2, 1, R2);
    drive_req(4'b0101);
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      if (n >= 32) begin
        check("bp_resp_valid", resp_valid, 4'b0010);
        check("bp_resp_data", resp_data, R1);
        check("bp_req_ready", req_ready, 4'b0000);
      end
    end
    @(posedge clk); #1;
    resp_ready = 4'b1111;
    wait_grant(t);
    drive_req(4'b0000);
    wait_done();

    // Timeout on requester 1; pending requester 3 granted next
    core_lat = 0;
    push_job(1, D1, 0, '0);
    drive_req(4'b0010);
    wait_grant(t);
    push_job(3, D3, 1, R3);
    drive_req(4'b1000);
    te_cnt = 0;
    for (int n = 1; n <= 67; n++) begin
      @(negedge clk);
      if (n == 2) core_lat = 30;
      te_cnt += int'(timeout_err);
      if (n == 65) check("to_busy_T65", busy, 1);
      if (n == 66) begin
        check("to_err_T66", timeout_err, 1);
        check("to_busy_T66", busy, 0);
        check("to_next_grant", req_ready, 4'b1000);
      end
    end
    check("to_pulse_count", te_cnt, 1);
    drive_req(4'b0000);
    wait_done();

    // Boundary: done on the 64th WAIT cycle
    core_lat = 64;
    push_job(0, D0, 1, R0);
    drive_req(4'b0001);
    wait_grant(t);
    drive_req(4'b0000);
    te_cnt = 0;
    for (int n = 1; n <= 67; n++) begin
      @(negedge clk);
      if (n == 2) core_lat = 30;
      te_cnt += int'(timeout_err);
      if (n == 65) check("bnd_resp_T65", resp_valid, 4'b0000);
      if (n == 66) begin
        check("bnd_resp_T66", resp_valid, 4'b0001);
        check("bnd_data_T66", resp_data, R0);
      end
    end
    check("bnd_no_err", te_cnt, 0);
    wait_done();

    // Spurious done while idle
    @(negedge clk);
    spurious = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("spur_busy", busy, 0);
      check("spur_resp_valid", resp_valid, 4'b0000);
      check("spur_resp_data", resp_data, R0);
    end

    // Reset mid-WAIT, then rr_ptr must be back at 0
    push_job(2, D2, 0, '0);
    drive_req(4'b0100);
    wait_grant(t);
    drive_req(4'b0000);
    repeat (10) @(negedge clk);
    check("rw_busy", busy, 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_zero("rst_wait");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    push_job(0, D0, 1, R0);
    drive_req(4'b1001);
    wait_grant(t);
    drive_req(4'b0000);
    wait_done();

    // Reset mid-RESP (rr_ptr was 1, so requester 3 would win without the reset)
    resp_ready = 4'b1011;
    push_job(2, D2, 0, '0);
    drive_req(4'b0100);
    wait_grant(t);
    drive_req(4'b0000);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (resp_valid[2]) got = 1'b1;
    end
    check("rr_resp_seen", got, 1);
    check("rr_resp_data", resp_data, R2);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_zero("rst_resp");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    resp_ready = 4'b1111;
    push_job(0, D0, 1, R0);
    drive_req(4'b1001);
    wait_grant(t);
    drive_req(4'b0000);
    wait_done();

    repeat (5) @(negedge clk);
    check("grant_q_empty", exp_grant_q.size(), 0);
    check("core_q_empty", exp_core_q.size(), 0);
    check("resp_q_empty", exp_resp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : global_guard
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got %0d vectors", n_vec);
    $fatal(1, "global timeout");
  end

endmodule
